sprite_row_reader: RTL

Sequential reader for the sprite graphics ROM. It accepts a request for one row of one sprite and drives the ROM address. It then captures the 32-bit row word and streams it out as 32 one-bit pixels over a valid/ready handshake. It sits between the frame/sprite drawing logic (requester) and the sprite ROM (combinational, 8-bit address, 32-bit data), and feeds per-pixel on/off to the colour mapper.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_shifter.sv | 42 ++++
 rtl/sprite_row_reader.sv | 119 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite row reader: sprite ids, geometry
// constants and the reader state encoding.
package sprite_pkg;

  localparam int SPRITE_W    = 32;
  localparam int SPRITE_H    = 32;
  localparam int NUM_SPRITES = 6;

  typedef enum logic [2:0] {
    SPR_TANK_UP    = 3'd0,
    SPR_TANK_LEFT  = 3'd1,
    SPR_TANK_DOWN  = 3'd2,
    SPR_TANK_RIGHT = 3'd3,
    SPR_BULLET     = 3'd4,
    SPR_BRICK      = 3'd5
  } sprite_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHIFT = 2'd3
  } reader_state_t;

endpackage

// File: rtl/sprite_shifter.sv
// Row shift register and column counter. A loaded row word is presented one
// bit at a time, MSB first, or LSB first when mirror is set.
module sprite_shifter #(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [W-1:0]  load_word,
  input  logic          shift,
  input  logic          mirror,
  output logic          pixel_bit,
  output logic [CW-1:0] col
);

  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  logic [W-1:0] shreg;

  // Row data: load a fresh word, or move the next pixel into the output slot
  always_ff @(posedge clk) begin
    if (load)
      shreg <= load_word;
    else if (shift)
      shreg <= mirror ? (shreg >> 1) : (shreg << 1);
  end

  // Column counter: cleared on a new request, saturates at the last column
  always_ff @(posedge clk) begin
    if (reset)
      col <= '0;
    else if (clear)
      col <= '0;
    else if (shift && (col != LAST_COL))
      col <= col + 1'b1;
  end

  assign pixel_bit = mirror ? shreg[0] : shreg[W-1];

endmodule

// File: rtl/sprite_row_reader.sv
// Sprite row reader: fetches one 32-bit row from the external sprite ROM and
// streams it out as 32 one-bit pixels over a valid/ready handshake.
// Optional feature macro: SPRITE_MIRROR_EN adds the mirror input, which
// streams the row LSB first (horizontal flip).
module sprite_row_reader #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int NUM_SPRITES = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [2:0]  sprite_sel,
  input  logic [4:0]  row,
`ifdef SPRITE_MIRROR_EN
  input  logic        mirror,
`endif
  output logic [7:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel_on,
  output logic [4:0]  pixel_col,
  output logic        busy,
  output logic        done,
  output logic        bad_sel
);

  import sprite_pkg::*;

  localparam logic [2:0] NUM_SEL  = 3'(NUM_SPRITES);
  localparam logic [4:0] LAST_COL = 5'(SPRITE_W - 1);

  reader_state_t state;
  logic          bad_req;
  logic          mirror_q;
  logic          sel_bad;
  logic          accept;
  logic          pixel_bit;
  logic [$clog2(SPRITE_H)-1:0] row_in;

  assign row_in  = row;
  assign sel_bad = (sprite_sel >= NUM_SEL);
  assign accept  = (state == ST_IDLE) && start;

`ifdef SPRITE_MIRROR_EN
  // Mirror choice is captured with the request and held for the whole row
  always_ff @(posedge Clk) begin
    if (Reset)
      mirror_q <= 1'b0;
    else if (accept)
      mirror_q <= mirror;
  end
`else
  assign mirror_q = 1'b0;
`endif

  // Request sequencing: IDLE -> FETCH -> LOAD -> SHIFT (32 pixels) -> IDLE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      rom_addr    <= 8'd0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bad_sel     <= 1'b0;
      bad_req     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            busy     <= 1'b1;
            bad_req  <= sel_bad;
            // Out-of-range ids read address 0; their row is blanked at LOAD
            rom_addr <= sel_bad ? 8'd0 : {sprite_sel, row_in};
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
          if (bad_req)
            bad_sel <= 1'b1;
        end
        ST_LOAD: begin
          state       <= ST_SHIFT;
          pixel_valid <= 1'b1;
        end
        ST_SHIFT: begin
          if (pixel_ready && (pixel_col == LAST_COL)) begin
            state       <= ST_IDLE;
            pixel_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sprite_shifter #(
    .W  (SPRITE_W),
    .CW (5)
  ) u_shifter (
    .clk       (Clk),
    .reset     (Reset),
    .clear     (accept),
    .load      (state == ST_LOAD),
    .load_word (bad_req ? 32'd0 : rom_data),
    .shift     ((state == ST_SHIFT) && pixel_ready),
    .mirror    (mirror_q),
    .pixel_bit (pixel_bit),
    .col       (pixel_col)
  );

  assign pixel_on = pixel_valid & pixel_bit;

endmodule
